// File: rtl/aes_inv_core_pkg.sv
// Shared AES-128 inverse-cipher types, sizes and GF(2^8) helpers.
// Pure declarations: no latency, no flow control.
package aes_inv_core_pkg;

  localparam int AES_NR    = 10;
  localparam int BLK_W     = 128;
  localparam int KEY_BUS_W = BLK_W * (AES_NR + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } fsm_e;

  // Multiply by {02} modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; row 0 sits in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_core_if.sv
// Request/result bundle for the AES-128 inverse core; master drives start and data.
// Single-cycle start request, no backpressure: start is ignored while busy.
interface aes_inv_core_if;
  import aes_inv_core_pkg::*;

  logic                 start;
  logic [BLK_W-1:0]     cipher_text;
  logic [KEY_BUS_W-1:0] exp_key;
  logic [BLK_W-1:0]     plain_text;
  logic                 done;
  logic                 busy;

  modport master (output start, cipher_text, exp_key, input plain_text, done, busy);
  modport slave  (input start, cipher_text, exp_key, output plain_text, done, busy);
endinterface

// File: rtl/aes_inv_core_sbox.sv
// Combinational AES inverse S-box, 8 bit in / 8 bit out.
// Zero latency, no flow control.
module aes_inv_core_sbox (
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign dat_o = INV_SBOX[dat_i];

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher, one round per clock; done pulses 10 cycles after the accepting edge.
// No backpressure: start is sampled only while idle and never queued; one block per 11 cycles.
module aes_inv_core
  import aes_inv_core_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic          clock,
  input  logic          reset,
  aes_inv_core_if.slave bus
);

  fsm_e             fsm_q, fsm_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] pt_q,  pt_d;
  logic             done_q, done_d;

  logic [BLK_W-1:0] rk [NR+1];
  logic [BLK_W-1:0] sub;
  logic [BLK_W-1:0] ark;
  logic [BLK_W-1:0] mixed;

  always_comb begin
    for (int i = 0; i <= NR; i++) begin
      rk[i] = bus.exp_key[BLK_W*i +: BLK_W];
    end
  end

  // InvShiftRows is pure wiring: byte (r,c) is fed from (r,c-r mod 4) into its S-box.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int R   = n % 4;
    localparam int C   = n / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    aes_inv_core_sbox u_sbox (
      .dat_i (blk_q[127-8*SRC -: 8]),
      .dat_o (sub[127-8*n -: 8])
    );
  end

  assign ark = sub ^ rk[rnd_q];

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q  <= ST_IDLE;
      blk_q  <= '0;
      rnd_q  <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rnd_q  <= rnd_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (bus.start) fsm_d = ST_ROUND;
      ST_ROUND: if (rnd_q == 4'd0) fsm_d = ST_IDLE;
    endcase
  end

  // Round 0 reuses the AddRoundKey output directly, which skips InvMixColumns.
  always_comb begin
    blk_d  = blk_q;
    rnd_d  = rnd_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          blk_d = bus.cipher_text ^ rk[NR];
          rnd_d = 4'(NR - 1);
        end
      end
      ST_ROUND: begin
        if (rnd_q != 4'd0) begin
          blk_d = mixed;
          rnd_d = rnd_q - 4'd1;
        end else begin
          blk_d  = ark;
          pt_d   = ark;
          done_d = 1'b1;
        end
      end
    endcase
  end

  assign bus.busy       = (fsm_q == ST_ROUND);
  assign bus.done       = done_q;
  assign bus.plain_text = pt_q;

endmodule

// File: tb/tb_aes_inv_core.sv
// Bench for aes_inv_core: forward AES-128 model (S-box derived from GF inverse + affine map)
// produces ciphertexts; the DUT must recover the plaintext with the documented timing.
module tb_aes_inv_core;
  import aes_inv_core_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  aes_inv_core_if bus ();
  aes_inv_core dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int v = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ v;
      v = v * 2;
      if (v >= 256) v = v ^ 'h11b;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] rotl8(input int b, input int k);
    return 8'(((b << k) | (b >> (8 - k))) & 'hff);
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ek;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) ek[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] x;
    x = pt ^ ek[127:0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox[x[127-8*n -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int n = 0; n < 16; n++) x[127-8*n -: 8] = s[n];
      x = x ^ ek[128*rd +: 128];
    end
    return x;
  endfunction

  // Drives one request and waits (bounded) for done; checks busy and latency on the way.
  task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt);
    int lat = 0;
    bus.cipher_text = ct;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      tick();
      if (bus.done) lat = i;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_pt"}, bus.plain_text, exp_pt);
    check({tag, "_busy_fall"}, bus.busy, 0);
  endtask

  initial begin
    logic [1407:0] ek_c1, ek_b, ek_r;
    logic [127:0]  key_r, pt_r, ct_r, got;
    logic [1407:0] vec_key [2];
    logic [127:0]  vec_ct  [2];
    logic [127:0]  vec_pt  [2];
    int            ndone, k, last, inv;
    logic          prev_done;

    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256 && x != 0; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = y;
      sbox[x] = 8'(inv) ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ek_c1 = expand(C1_KEY);
    ek_b  = expand(B_KEY);

    reset = 1'b1;
    bus.start = 1'b0;
    bus.cipher_text = '0;
    bus.exp_key = ek_c1;
    repeat (3) tick();
    check("rst_pt", bus.plain_text, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();

    run_op("c1", C1_CT, C1_PT);
    bus.exp_key = ek_b;
    run_op("appb", B_CT, B_PT);

    for (int i = 0; i < 20; i++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      ek_r  = expand(key_r);
      ct_r  = encrypt(pt_r, ek_r);
      bus.exp_key = ek_r;
      run_op($sformatf("rand%0d", i), ct_r, pt_r);
    end

    // A second start arriving mid-operation must be dropped.
    bus.exp_key = ek_c1;
    bus.cipher_text = C1_CT;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.cipher_text = B_CT;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    got = '0;
    prev_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("ign_done_consec", bus.done & prev_done, 0);
      prev_done = bus.done;
      if (bus.done) begin
        ndone++;
        got = bus.plain_text;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_pt", got, C1_PT);

    // Reset in the middle of an operation discards it.
    bus.cipher_text = C1_CT;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_pt", bus.plain_text, 0);
    check("abort_done", bus.done, 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("abort_ndone", ndone, 0);
    run_op("after_abort", C1_CT, C1_PT);

    // start held high with alternating vectors; inputs switch when each result appears.
    vec_key[0] = ek_c1; vec_ct[0] = C1_CT; vec_pt[0] = C1_PT;
    vec_key[1] = ek_b;  vec_ct[1] = B_CT;  vec_pt[1] = B_PT;
    k = 0;
    last = 0;
    bus.exp_key = vec_key[0];
    bus.cipher_text = vec_ct[0];
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
      tick();
      if (bus.done) begin
        check($sformatf("b2b_pt%0d", k), bus.plain_text, vec_pt[k%2]);
        if (k > 0) check($sformatf("b2b_gap%0d", k), cyc - last, 11);
        last = cyc;
        k++;
        bus.exp_key = vec_key[k%2];
        bus.cipher_text = vec_ct[k%2];
      end
    end
    bus.start = 1'b0;
    check("b2b_count", k, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_core.md
# aes_inv_core

Iterative AES-128 inverse cipher (FIPS-197 §5.3): turns a 128-bit ciphertext back into plaintext, one round per clock, using the 11 round keys already produced by `key_expansion`. It is the decrypt counterpart of `aes_core` and consumes the same expanded-key bus. The `key_expansion` instance is shared, and this block never re-derives keys.

## Interface
Parameters:
- `NR`, 10, number of rounds; fixed for AES-128 and not meant to be overridden.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only while idle.
- `cipher_text`  in  128  ciphertext, sampled on the accepting edge.
- `exp_key`  in  1408  round key i at `[128*i+127:128*i]`; key[0] is the cipher key. Must be stable while `busy`.
- `plain_text`  out  128  result, registered, held until the next accepted `start` completes.
- `done`  out  1  one-cycle pulse when `plain_text` is updated.
- `busy`  out  1  high from the accepting edge through the final-round edge.

## Operation
- Byte order: bits `[127:120]` are state byte 0, s[0][0]. Column-major as in FIPS-197.
- FSM states:
  - IDLE: waits for `start`. On `start`, loads state = `cipher_text ^ key[10]`, sets `rnd` = 9, and goes to ROUND.
  - ROUND: while `rnd` ≥ 1, each edge computes state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), key[rnd])), then `rnd` decrements.
    - When `rnd` = 0, the final round computes state = InvSubBytes(InvShiftRows(state)) ^ key[0] with no InvMixColumns.
    - The final-round edge writes `plain_text`, pulses `done`, and returns to IDLE.
- InvShiftRows: row r is rotated right by r bytes.
- InvMixColumns: fixed matrix {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11B, built from chained xtime. No multipliers.
- `rnd` is 4 bits. Key select is a mux on `rnd` over the 11 slices.
- `start` while `busy` is ignored and is not queued.
- `start` and `reset` in the same cycle: `reset` wins.
- `reset` mid-operation aborts immediately and returns to IDLE; the partial result is discarded.
- Reset values: `plain_text`=0, `done`=0, `busy`=0, state=0, `rnd`=0, FSM=IDLE.

## Timing
- Accepting edge T0 (IDLE, `start`=1): `busy`=1 from T0.
- Edges T1–T9: the nine full rounds.
- Edge T10: final round. `plain_text` is valid and `done`=1 for the cycle after T10. `busy` falls at T10.
- Latency is 10 cycles from the accepting edge to `done`. The next `start` can be accepted at T10+1, so throughput is one block per 11 cycles.
- `done` is never high for two consecutive cycles.
- `exp_key` changes while `busy` produce an undefined result. `cipher_text` is don't-care after T0.

## Structure
- Shared `aes_pkg`, also used by `aes_core`: `NR`, `NK`, the round-key slice width, the xtime/GF-multiply functions, and the byte/column index helpers.
- Sub-module `aes_inv_sbox`: a combinational 256-entry InvSubBytes table, 8 bit in / 8 bit out. It is instantiated 16 times and keeps the table out of the core.
- Core RTL size: roughly 180–250 lines, excluding the S-box table.

## Test plan
- FIPS-197 C.1: `exp_key` from key 000102030405060708090a0b0c0d0e0f, `cipher_text` 69c4e0d86a7b0430d8cdb78070b4c55a -> `plain_text` 00112233445566778899aabbccddeeff, with `done` exactly 10 cycles after `start`.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Round trip: drive 50 random keys and plaintexts through `aes_core` and then `aes_inv_core` with a shared `key_expansion` -> recovered plaintext matches the original every time.
- `start` pulsed at T3 of the C.1 operation with a different ct -> ignored: a single `done`, with the C.1 result.
- `reset` asserted at T5 -> `busy`=0, `done` never pulses, and `plain_text` reads 0 the next cycle. A new `start` afterwards gives the correct C.1 result.
- Back-to-back: `start` held high continuously with the two vectors alternating -> `done` every 11 cycles, with results correct and in order.
